// File: rtl/flex_counter_pkg.sv
// Shared definitions for the flex counter family (up- and down-counting variants).
// Holds the common state encoding and the default counter width.
package flex_counter_pkg;

    // Counter lifecycle: idle until loaded, counting, or expired and waiting.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } flex_state_t;

    localparam int DEFAULT_CNT_BITS = 4;

endpackage : flex_counter_pkg

// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with done level and one-cycle expire strobe.
// Optional feature macro: FLEX_DOWN_AUTO_RELOAD_EN
//   defined   - expiry reloads count_out from reload_reg and keeps counting (periodic timer)
//   undefined - expiry drops count_out to 0 and parks in DONE until load or clear
// Edge priority: clear > load > count_enable > hold. All outputs are registered.
module flex_down_counter
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    done_flag,
    output logic                    expire_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1'b1);

    flex_state_t             state_r;
    logic [NUM_CNT_BITS-1:0] reload_reg;

    flex_state_t             state_s;
    logic [NUM_CNT_BITS-1:0] count_s;
    logic [NUM_CNT_BITS-1:0] reload_s;
    logic                    pulse_s;
    logic                    busy_s;
    logic                    done_s;

    // Next-state and next-output computation; everything holds unless a rule below fires.
    always_comb begin
        state_s  = state_r;
        count_s  = count_out;
        reload_s = reload_reg;
        pulse_s  = 1'b0;

        if (clear) begin
            // reload_reg deliberately survives a clear so a later restart can reuse it
            state_s = IDLE;
            count_s = CNT_ZERO;
        end else if (load) begin
            if (load_val != CNT_ZERO) begin
                // Restart, even mid-count; a restart is not an expiry, so no strobe
                reload_s = load_val;
                count_s  = load_val;
                state_s  = COUNT;
            end else begin
                // A zero-length timer expires immediately
                count_s = CNT_ZERO;
                state_s = DONE;
                pulse_s = 1'b1;
            end
        end else begin
            case (state_r)
                COUNT: begin
                    if (count_enable) begin
                        if (count_out > CNT_ONE) begin
                            count_s = count_out - CNT_ONE;
                        end else if (count_out == CNT_ONE) begin
`ifdef FLEX_DOWN_AUTO_RELOAD_EN
                            // Wrap straight back to the period; 0 is never shown while counting
                            count_s = reload_reg;
                            state_s = COUNT;
`else
                            count_s = CNT_ZERO;
                            state_s = DONE;
`endif
                            pulse_s = 1'b1;
                        end else begin
                            // Unreachable (COUNT is never entered with 0); hold rather than wrap
                            count_s = count_out;
                        end
                    end else begin
                        count_s = count_out;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    // Illegal encoding: recover to a safe idle state
                    state_s = IDLE;
                    count_s = CNT_ZERO;
                end
            endcase
        end

        // Status levels follow the state being entered so they line up with count_out
        busy_s = (state_s == COUNT);
        done_s = (state_s == DONE);
    end

    // State, count, reload value and status flags; async reset clears everything at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= IDLE;
            count_out    <= CNT_ZERO;
            reload_reg   <= CNT_ZERO;
            busy         <= 1'b0;
            done_flag    <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_out    <= count_s;
            reload_reg   <= reload_s;
            busy         <= busy_s;
            done_flag    <= done_s;
            expire_pulse <= pulse_s;
        end
    end

endmodule : flex_down_counter

// File: tb/tb_flex_down_counter.sv
// Directed self-checking bench for flex_down_counter with hand-computed expectations.
// The auto-reload scenario is compiled in when FLEX_DOWN_AUTO_RELOAD_EN is defined.
module tb_flex_down_counter;

    localparam int W = 4;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         load;
    logic         count_enable;
    logic [W-1:0] load_val;
    logic [W-1:0] count_out;
    logic         busy;
    logic         done_flag;
    logic         expire_pulse;

    int n_checks;
    int n_fail;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .count_enable (count_enable),
        .load_val     (load_val),
        .count_out    (count_out),
        .busy         (busy),
        .done_flag    (done_flag),
        .expire_pulse (expire_pulse)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, then settle 1 ns past it.
    task automatic tick(input logic c, input logic l, input logic ce, input logic [W-1:0] lv);
        clear        = c;
        load         = l;
        count_enable = ce;
        load_val     = lv;
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs at once.
    task automatic expect_all(input string tag, input int cnt, input logic b, input logic d,
                              input logic p);
        check_val({tag, ".count"}, 32'(count_out), 32'(cnt));
        check_val({tag, ".busy"},  32'(busy),      32'(b));
        check_val({tag, ".done"},  32'(done_flag), 32'(d));
        check_val({tag, ".pulse"}, 32'(expire_pulse), 32'(p));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_rst        = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        count_enable = 1'b0;
        load_val     = 4'd0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all("reset", 0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;

        // 1. Asynchronous reset mid-count
        tick(1'b0, 1'b1, 1'b0, 4'd5);
        expect_all("t1_load5", 5, 1'b1, 1'b0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        expect_all("t1_async_rst", 0, 1'b0, 1'b0, 1'b0);
        #2 n_rst = 1'b1;

        // 2. Load 3, count to expiry
        tick(1'b0, 1'b1, 1'b0, 4'd3);
        expect_all("t2_load3", 3, 1'b1, 1'b0, 1'b0);
`ifndef FLEX_DOWN_AUTO_RELOAD_EN
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t2_c2", 2, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t2_c1", 1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t2_c0", 0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t2_done_hold", 0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        expect_all("t2_done_idle_in", 0, 1'b0, 1'b1, 1'b0);

        // Boundary: load 1 expires on the first enabled cycle
        tick(1'b0, 1'b1, 1'b0, 4'd1);
        expect_all("b_load1", 1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("b_load1_exp", 0, 1'b0, 1'b1, 1'b1);
`endif

        // 3. Enable pattern 1,0,0,1
        tick(1'b0, 1'b1, 1'b0, 4'd4);
        expect_all("t3_load4", 4, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t3_e1", 3, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        expect_all("t3_e0a", 3, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 4'd0);
        expect_all("t3_e0b", 3, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t3_e1b", 2, 1'b1, 1'b0, 1'b0);

        // 4. Restart at 2 with 7, then zero load; load beats count_enable
        tick(1'b0, 1'b1, 1'b1, 4'd7);
        expect_all("t4_reload7", 7, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 4'd0);
        expect_all("t4_zero_load", 0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t4_done_ce_ignored", 0, 1'b0, 1'b1, 1'b0);

        // 5. Clear from DONE, then clear beats load
        tick(1'b1, 1'b0, 1'b0, 4'd0);
        expect_all("t5_clear_done", 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'd5);
        expect_all("t5_load5", 5, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 4'd9);
        expect_all("t5_clear_load", 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t5_idle_ce_ignored", 0, 1'b0, 1'b0, 1'b0);

`ifdef FLEX_DOWN_AUTO_RELOAD_EN
        // 6. Auto-reload period 3: 3,2,1,3,2,1,3
        tick(1'b0, 1'b1, 1'b0, 4'd3);
        expect_all("t6_load3", 3, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_2a", 2, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_1a", 1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_wrap1", 3, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_2b", 2, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_1b", 1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd0);
        expect_all("t6_wrap2", 3, 1'b1, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flex_down_counter
